// File: rtl/adma_dm_pkg.sv
// Shared types and constants for the DMA source-side read host.
package adma_dm_pkg;

    typedef enum logic [1:0] {
        SPLIT_IDLE  = 2'd0,
        SPLIT_CALC  = 2'd1,
        SPLIT_ISSUE = 2'd2
    } split_state_e;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam int unsigned AXI_4KB        = 4096;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/adma_dm_rd_chn_trk.sv
// Per-channel transfer tracker: busy flag, read ID, remaining beats,
// outstanding burst credit and sticky error.
module adma_dm_rd_chn_trk
    import adma_dm_pkg::*;
#(
    parameter int MST_ID_W     = 5,
    parameter int XFER_BEATS_W = 16,
    parameter int OSTD_W       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [MST_ID_W-1:0]     start_id,
    input  logic [XFER_BEATS_W-1:0] start_beats,
    input  logic                    ar_inc,
    input  logic [MST_ID_W-1:0]     rid,
    input  logic                    r_hs,
    input  logic                    r_last,
    input  logic [1:0]              r_resp,
    input  logic                    err_clr,
    output logic                    busy,
    output logic                    id_match,
    output logic                    last_beat,
    output logic [OSTD_W-1:0]       ostd,
    output logic                    err
);

    logic [MST_ID_W-1:0]     id_q;
    logic [XFER_BEATS_W-1:0] beats_q;
    logic                    resp_err;

    always_comb begin
        id_match  = busy && (id_q == rid);
        last_beat = (beats_q == XFER_BEATS_W'(1));
        resp_err  = (r_resp == RESP_SLVERR) || (r_resp == RESP_DECERR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            id_q    <= '0;
            beats_q <= '0;
            ostd    <= '0;
            err     <= 1'b0;
        end else begin
            if (start) begin
                busy    <= 1'b1;
                id_q    <= start_id;
                beats_q <= start_beats;
            end else if (r_hs) begin
                beats_q <= beats_q - 1'b1;
                if (last_beat) busy <= 1'b0;
            end

            case ({ar_inc, r_hs && r_last})
                2'b10:   ostd <= ostd + 1'b1;
                2'b01:   ostd <= ostd - 1'b1;
                default: ostd <= ostd;
            endcase

            // A new error in the same cycle as a clear must stick.
            if (r_hs && resp_err) err <= 1'b1;
            else if (err_clr)     err <= 1'b0;
        end
    end

    a_beat_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        r_hs |-> (beats_q != '0));

endmodule

// File: rtl/adma_dm_rd_split_host.sv
// Multi-channel DMA read host: splits transfers into 4KB-safe INCR bursts,
// enforces per-channel AR credit and routes R beats back by ID.
module adma_dm_rd_split_host
    import adma_dm_pkg::*;
#(
    parameter int DMA_CHN_NUM    = 4,
    parameter int SRC_ADDR_W     = 32,
    parameter int MST_ID_W       = 5,
    parameter int ATX_LEN_W      = 8,
    parameter int ATX_SRC_DATA_W = 256,
    parameter int XFER_BEATS_W   = 16,
    parameter int MAX_BURST      = 16,
    parameter int CHN_OSTD       = 2,
    parameter int DMA_CHN_NUM_W  = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DMA_CHN_NUM_W-1:0]  xfer_chn_id,
    input  logic [MST_ID_W-1:0]       xfer_arid,
    input  logic [SRC_ADDR_W-1:0]     xfer_addr,
    input  logic [XFER_BEATS_W-1:0]   xfer_beats,
    input  logic                      xfer_vld,
    output logic                      xfer_rdy,
    output logic                      xfer_done,
    output logic [DMA_CHN_NUM_W-1:0]  xfer_done_chn,
    output logic [ATX_SRC_DATA_W-1:0] rdata,
    output logic [DMA_CHN_NUM_W-1:0]  rdata_chn,
    output logic                      rdata_last,
    output logic                      rdata_vld,
    input  logic                      rdata_rdy,
    output logic [DMA_CHN_NUM-1:0]    chn_err,
    input  logic [DMA_CHN_NUM-1:0]    err_clr,
    output logic                      unk_rid,
    output logic [MST_ID_W-1:0]       m_arid_o,
    output logic [SRC_ADDR_W-1:0]     m_araddr_o,
    output logic [ATX_LEN_W-1:0]      m_arlen_o,
    output logic [2:0]                m_arsize_o,
    output logic [1:0]                m_arburst_o,
    output logic                      m_arvalid_o,
    input  logic                      m_arready_i,
    input  logic [MST_ID_W-1:0]       m_rid_i,
    input  logic [ATX_SRC_DATA_W-1:0] m_rdata_i,
    input  logic [1:0]                m_rresp_i,
    input  logic                      m_rlast_i,
    input  logic                      m_rvalid_i,
    output logic                      m_rready_o
);

    localparam int BYTES  = ATX_SRC_DATA_W / 8;
    localparam int BSIZE  = $clog2(BYTES);
    localparam int OSTD_W = $clog2(CHN_OSTD + 1);

    split_state_e state, state_nxt;

    logic [DMA_CHN_NUM_W-1:0] cur_chn;
    logic [MST_ID_W-1:0]      cur_id;
    logic [SRC_ADDR_W-1:0]    cur_addr;
    logic [XFER_BEATS_W-1:0]  remaining, burst_len, calc_len, page_room;
    logic                     xfer_hs, credit_ok, match_any, r_hs_any;
    logic [DMA_CHN_NUM_W-1:0] match_chn;
    logic [DMA_CHN_NUM-1:0]   chn_busy, id_match, last_beat, start, ar_inc, r_hs;
    logic [OSTD_W-1:0]        chn_ostd [DMA_CHN_NUM];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= SPLIT_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SPLIT_IDLE:  if (xfer_hs)   state_nxt = SPLIT_CALC;
            SPLIT_CALC:  if (credit_ok) state_nxt = SPLIT_ISSUE;
            SPLIT_ISSUE: if (m_arready_i)
                state_nxt = (remaining == burst_len) ? SPLIT_IDLE : SPLIT_CALC;
            default:     state_nxt = SPLIT_IDLE;
        endcase
    end

    always_comb begin
        xfer_rdy    = (state == SPLIT_IDLE) && !chn_busy[xfer_chn_id];
        m_arvalid_o = (state == SPLIT_ISSUE);
    end

    always_comb begin
        xfer_hs   = xfer_vld && xfer_rdy;
        credit_ok = chn_ostd[cur_chn] != OSTD_W'(CHN_OSTD);
        page_room = XFER_BEATS_W'((AXI_4KB - 32'(cur_addr[11:0])) >> BSIZE);
        calc_len  = remaining;
        if (calc_len > XFER_BEATS_W'(MAX_BURST)) calc_len = XFER_BEATS_W'(MAX_BURST);
        if (calc_len > page_room)                calc_len = page_room;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_chn    <= '0;
            cur_id     <= '0;
            cur_addr   <= '0;
            remaining  <= '0;
            burst_len  <= '0;
            m_arid_o   <= '0;
            m_araddr_o <= '0;
            m_arlen_o  <= '0;
        end else begin
            if (state == SPLIT_IDLE && xfer_hs) begin
                cur_chn   <= xfer_chn_id;
                cur_id    <= xfer_arid;
                cur_addr  <= xfer_addr;
                remaining <= xfer_beats;
            end
            if (state == SPLIT_CALC && credit_ok) begin
                burst_len  <= calc_len;
                m_arid_o   <= cur_id;
                m_araddr_o <= cur_addr;
                m_arlen_o  <= ATX_LEN_W'(calc_len - 1'b1);
            end
            if (state == SPLIT_ISSUE && m_arready_i) begin
                cur_addr  <= cur_addr + (SRC_ADDR_W'(burst_len) << BSIZE);
                remaining <= remaining - burst_len;
            end
        end
    end

    assign m_arsize_o  = 3'(BSIZE);
    assign m_arburst_o = AXI_BURST_INCR;

    // Busy-channel IDs are distinct, so at most one tracker matches.
    always_comb begin
        match_any = 1'b0;
        match_chn = '0;
        for (int unsigned i = 0; i < DMA_CHN_NUM; i++) begin
            if (id_match[i] && !match_any) begin
                match_any = 1'b1;
                match_chn = DMA_CHN_NUM_W'(i);
            end
        end
        rdata      = m_rdata_i;
        rdata_chn  = match_chn;
        rdata_vld  = m_rvalid_i && match_any;
        rdata_last = match_any && last_beat[match_chn];
        m_rready_o = match_any ? rdata_rdy : 1'b1;
        unk_rid    = m_rvalid_i && !match_any;
        r_hs_any   = rdata_vld && rdata_rdy;
        for (int unsigned i = 0; i < DMA_CHN_NUM; i++) begin
            start[i]  = xfer_hs && (xfer_chn_id == DMA_CHN_NUM_W'(i));
            ar_inc[i] = (state == SPLIT_ISSUE) && m_arready_i && (cur_chn == DMA_CHN_NUM_W'(i));
            r_hs[i]   = r_hs_any && (match_chn == DMA_CHN_NUM_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_done     <= 1'b0;
            xfer_done_chn <= '0;
        end else begin
            xfer_done     <= r_hs_any && last_beat[match_chn];
            xfer_done_chn <= match_chn;
        end
    end

    for (genvar g = 0; g < DMA_CHN_NUM; g++) begin : g_trk
        adma_dm_rd_chn_trk #(
            .MST_ID_W    (MST_ID_W),
            .XFER_BEATS_W(XFER_BEATS_W),
            .OSTD_W      (OSTD_W)
        ) u_trk (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start[g]),
            .start_id   (xfer_arid),
            .start_beats(xfer_beats),
            .ar_inc     (ar_inc[g]),
            .rid        (m_rid_i),
            .r_hs       (r_hs[g]),
            .r_last     (m_rlast_i),
            .r_resp     (m_rresp_i),
            .err_clr    (err_clr[g]),
            .busy       (chn_busy[g]),
            .id_match   (id_match[g]),
            .last_beat  (last_beat[g]),
            .ostd       (chn_ostd[g]),
            .err        (chn_err[g])
        );
    end

    a_zero_beats: assert property (@(posedge clk) disable iff (!rst_n)
        xfer_hs |-> (xfer_beats != '0));
    a_misaligned: assert property (@(posedge clk) disable iff (!rst_n)
        xfer_hs |-> ((xfer_addr & SRC_ADDR_W'(BYTES - 1)) == '0));

endmodule
